// File: rtl/hvsync_pkg.sv
// Raster timing defaults for the terminal video path plus the derived
// wrap and sync-window points, and a small window-compare helper.
package hvsync_pkg;

  localparam int H_DISPLAY_D = 256;
  localparam int H_BACK_D    = 23;
  localparam int H_FRONT_D   = 7;
  localparam int H_SYNC_D    = 23;
  localparam int V_DISPLAY_D = 240;
  localparam int V_TOP_D     = 5;
  localparam int V_BOTTOM_D  = 14;
  localparam int V_SYNC_D    = 3;

  localparam int H_MAX_D        = H_DISPLAY_D + H_BACK_D + H_FRONT_D + H_SYNC_D - 1;
  localparam int H_SYNC_START_D = H_DISPLAY_D + H_FRONT_D;
  localparam int H_SYNC_END_D   = H_SYNC_START_D + H_SYNC_D - 1;
  localparam int V_MAX_D        = V_DISPLAY_D + V_TOP_D + V_BOTTOM_D + V_SYNC_D - 1;
  localparam int V_SYNC_START_D = V_DISPLAY_D + V_BOTTOM_D;
  localparam int V_SYNC_END_D   = V_SYNC_START_D + V_SYNC_D - 1;

  // Inclusive window test on 9-bit beam coordinates.
  function automatic logic in_window(input logic [8:0] x,
                                     input logic [8:0] lo,
                                     input logic [8:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/hv_sync_generator_mod_counter.sv
// Wrapping up-counter: advances when i_en is set, returns to 0 after MAX.
module mod_counter #(
  parameter int             W   = 9,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count with wrap; async reset returns the beam to the origin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= (r_cnt == MAX) ? '0 : r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hv_sync_generator.sv
// Free-running raster timing generator: beam counters, registered sync
// pulses (one clk behind the counters) and a zero-latency visible flag.
// Define HVSYNC_NEG_POLARITY_EN for active-low hsync/vsync; counters and
// display_on are the same in both builds.
module hv_sync_generator
  import hvsync_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_D,
  parameter int H_BACK    = H_BACK_D,
  parameter int H_FRONT   = H_FRONT_D,
  parameter int H_SYNC    = H_SYNC_D,
  parameter int V_DISPLAY = V_DISPLAY_D,
  parameter int V_TOP     = V_TOP_D,
  parameter int V_BOTTOM  = V_BOTTOM_D,
  parameter int V_SYNC    = V_SYNC_D
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [8:0] hpos,
  output logic [8:0] vpos
);

  localparam logic [8:0] H_MAX        = 9'(H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1);
  localparam logic [8:0] H_SYNC_START = 9'(H_DISPLAY + H_FRONT);
  localparam logic [8:0] H_SYNC_END   = 9'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [8:0] V_MAX        = 9'(V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1);
  localparam logic [8:0] V_SYNC_START = 9'(V_DISPLAY + V_BOTTOM);
  localparam logic [8:0] V_SYNC_END   = 9'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
  localparam logic [8:0] H_VIS        = 9'(H_DISPLAY);
  localparam logic [8:0] V_VIS        = 9'(V_DISPLAY);

`ifdef HVSYNC_NEG_POLARITY_EN
  localparam logic SYNC_ACT = 1'b0;
`else
  localparam logic SYNC_ACT = 1'b1;
`endif

  logic [8:0] w_hpos;
  logic [8:0] w_vpos;
  logic       w_h_wrap;
  logic       r_hsync;
  logic       r_vsync;

  // Vertical advances only on the edge where the line wraps.
  assign w_h_wrap = (w_hpos == H_MAX);

  mod_counter #(.W(9), .MAX(H_MAX)) u_hcnt (
    .clk   (clk),
    .reset (reset),
    .i_en  (1'b1),
    .o_cnt (w_hpos)
  );

  mod_counter #(.W(9), .MAX(V_MAX)) u_vcnt (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_h_wrap),
    .o_cnt (w_vpos)
  );

  // Sync pulses sampled from the pre-edge counters, so they trail by one clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hsync <= ~SYNC_ACT;
      r_vsync <= ~SYNC_ACT;
    end else begin
      r_hsync <= in_window(w_hpos, H_SYNC_START, H_SYNC_END) ? SYNC_ACT : ~SYNC_ACT;
      r_vsync <= in_window(w_vpos, V_SYNC_START, V_SYNC_END) ? SYNC_ACT : ~SYNC_ACT;
    end
  end

  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign hpos       = w_hpos;
  assign vpos       = w_vpos;
  assign display_on = (w_hpos < H_VIS) && (w_vpos < V_VIS);

endmodule

// File: tb/tb_hv_sync_generator.sv
// Scoreboard bench for hv_sync_generator: the stimulus process pushes the
// expected raster state after each clk edge, the monitor pops and compares
// on the following falling edge. Honours HVSYNC_NEG_POLARITY_EN.
module tb_hv_sync_generator;

  logic       clk = 1'b0;
  logic       reset;
  logic       hsync, vsync, display_on;
  logic [8:0] hpos, vpos;

  typedef struct {
    logic [8:0] h;
    logic [8:0] v;
    logic       hs;
    logic       vs;
    logic       de;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

`ifdef HVSYNC_NEG_POLARITY_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  hv_sync_generator dut (
    .clk        (clk),
    .reset      (reset),
    .hsync      (hsync),
    .vsync      (vsync),
    .display_on (display_on),
    .hpos       (hpos),
    .vpos       (vpos)
  );

  always #5 clk = ~clk;

  // Expected state t edges after reset release (t=0 is the reset state).
  // 309 clks/line, 262 lines/frame, hsync window 263..285, vsync 254..256.
  function automatic exp_t model(input int t, input string tag);
    exp_t e;
    int   hp, vp;
    e.h = 9'(t % 309);
    e.v = 9'((t / 309) % 262);
    if (t == 0) begin
      e.hs = 1'b0;
      e.vs = 1'b0;
    end else begin
      hp   = (t - 1) % 309;
      vp   = ((t - 1) / 309) % 262;
      e.hs = (hp >= 263) && (hp <= 285);
      e.vs = (vp >= 254) && (vp <= 256);
    end
    e.hs  = e.hs ^ INV;
    e.vs  = e.vs ^ INV;
    e.de  = (e.h < 9'd256) && (e.v < 9'd240);
    e.tag = tag;
    return e;
  endfunction

  // Monitor: one comparison per presented sample, plus line-period check.
  initial begin : monitor
    exp_t e;
    int   cyc;
    int   last256;
    cyc     = 0;
    last256 = -1;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        cyc++;
        n_vec++;
        if (hpos !== e.h || vpos !== e.v || hsync !== e.hs ||
            vsync !== e.vs || display_on !== e.de) begin
          n_err++;
          $display("FAIL %s cyc=%0d: got h=%0d v=%0d hs=%b vs=%b de=%b, exp h=%0d v=%0d hs=%b vs=%b de=%b",
                   e.tag, cyc, hpos, vpos, hsync, vsync, display_on,
                   e.h, e.v, e.hs, e.vs, e.de);
        end
        if (e.tag == "reset" || e.tag == "async_rst")
          last256 = -1;
        else if (hpos == 9'd256) begin
          if (last256 >= 0) begin
            n_vec++;
            if (cyc - last256 != 309) begin
              n_err++;
              $display("FAIL h256_period: got %0d clks, exp 309", cyc - last256);
            end
          end
          last256 = cyc;
        end
      end
    end
  end

  // Stimulus: reset, full frame plus a line, async reset mid-frame, rerun.
  initial begin : stim
    bit drained;
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk);
      q.push_back(model(0, "reset"));
    end
    @(negedge clk);
    reset = 1'b0;

    // Full frame wrap, then stop with the last sample at hpos=100, vpos=1.
    for (int t = 1; t <= 262 * 309 + 309 + 100; t++) begin
      @(posedge clk);
      q.push_back(model(t, "run"));
    end

    // Assert reset between edges; outputs must clear before any clk edge.
    @(posedge clk);
    #2;
    reset = 1'b1;
    q.push_back(model(0, "async_rst"));
    repeat (2) begin
      @(posedge clk);
      q.push_back(model(0, "reset"));
    end
    @(negedge clk);
    reset = 1'b0;

    // First line again from reset: 0..308, wrap, vpos 0->1.
    for (int t = 1; t <= 400; t++) begin
      @(posedge clk);
      q.push_back(model(t, "rerun"));
    end

    drained = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) begin
        drained = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (!drained) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending, exp 0", q.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
